// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter sharing one narrow converter port between NUM_REQ requesters.
// Sequences the two-cycle read protocol, routes read data to its owner, and times out lost reads.
module bram_access_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             rerr_o,
    output logic                             conv_en_o,
    output logic                             conv_we_o,
    output logic [ADDR_WIDTH-1:0]            conv_addr_o,
    output logic [DATA_WIDTH-1:0]            conv_din_o,
    input  logic [DATA_WIDTH-1:0]            conv_dout_i,
    input  logic                             conv_valid_i,
    input  logic                             conv_ready_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic               found;
    logic [IDX_W-1:0]   win;

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_i[(int'(last_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        tmo_cnt_d   = tmo_cnt_q;
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = '0;
        rerr_o      = 1'b0;
        conv_en_o   = 1'b0;
        conv_we_o   = 1'b0;
        conv_addr_o = '0;
        conv_din_o  = '0;

        case (state_q)
            IDLE: begin
                if (conv_ready_i && found) begin
                    gnt_o[win]  = 1'b1;
                    conv_en_o   = 1'b1;
                    conv_we_o   = we_i[win];
                    conv_addr_o = addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    conv_din_o  = we_i[win] ? wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
                    last_d      = win;
                    if (!we_i[win]) begin
                        state_d   = RD_WAIT;
                        owner_d   = win;
                        tmo_cnt_d = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (conv_valid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = conv_dout_i;
                    state_d           = IDLE;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rvalid_o[owner_q] = 1'b1;
                    rerr_o            = 1'b1;
                    state_d           = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs stay quiet for the whole reset window, not just after the edge.
        if (rst_i) begin
            gnt_o       = '0;
            rvalid_o    = '0;
            rdata_o     = '0;
            rerr_o      = 1'b0;
            conv_en_o   = 1'b0;
            conv_we_o   = 1'b0;
            conv_addr_o = '0;
            conv_din_o  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Randomized bench for bram_access_arbiter: a transaction-level model predicts grants and
// read responses into queues that a negedge monitor pops whenever the DUT presents them.
module tb_bram_access_arbiter;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int AW  = 7;
    localparam int TMO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_i = '0;
    logic [N-1:0]      we_i = '0;
    logic [N*AW-1:0]   addr_i = '0;
    logic [N*DW-1:0]   wdata_i = '0;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              rerr_o;
    logic              conv_en_o;
    logic              conv_we_o;
    logic [AW-1:0]     conv_addr_o;
    logic [DW-1:0]     conv_din_o;
    logic [DW-1:0]     conv_dout_i = '0;
    logic              conv_valid_i = 1'b0;
    logic              conv_ready_i = 1'b0;

    bram_access_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .rerr_o(rerr_o), .conv_en_o(conv_en_o), .conv_we_o(conv_we_o),
        .conv_addr_o(conv_addr_o), .conv_din_o(conv_din_o), .conv_dout_i(conv_dout_i),
        .conv_valid_i(conv_valid_i), .conv_ready_i(conv_ready_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          cyc;
        int          idx;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic        err;
    } txn_t;

    txn_t gnt_exp_q[$];
    txn_t rsp_exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // requester-side pending accesses
    logic            pend    [N];
    logic            p_we    [N];
    logic [AW-1:0]   p_addr  [N];
    logic [DW-1:0]   p_wdata [N];

    // reference-model state
    int              model_last;
    int              busy_end;
    int              rsp_valid_cyc;
    int              force_ready;
    int              next_delay;
    logic            stray_en;
    logic [AW-1:0]   lat_addr;

    function automatic logic [DW-1:0] conv_data(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = {{(DW-AW){1'b0}}, a ^ 7'h05};
        return 32'hDEADBEEF ^ (x * 32'h01000193);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        model_last    = N - 1;
        busy_end      = -1;
        rsp_valid_cyc = -1;
        force_ready   = -1;
        next_delay    = 0;
        stray_en      = 1'b0;
        lat_addr      = '0;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        gnt_exp_q.delete();
        rsp_exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1; req_i = '1; we_i = '0; conv_ready_i = 1'b1;
        conv_valid_i = 1'b1; conv_dout_i = 32'h12345678;
        #1;
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_conv_en", 64'(conv_en_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = '0; conv_valid_i = 1'b0; conv_ready_i = 1'b0;
        cyc++;
        model_reset();
    endtask

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic drive_cycle();
        logic [N-1:0]    rq, wv;
        logic [N*AW-1:0] av;
        logic [N*DW-1:0] dv;
        logic            rdy;
        int              w, d;
        txn_t            t, r;
        @(posedge clk_i); #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            rq[k] = pend[k];
            wv[k] = p_we[k];
            av[k*AW +: AW] = p_addr[k];
            dv[k*DW +: DW] = p_wdata[k];
        end
        req_i = rq; we_i = wv; addr_i = av; wdata_i = dv;
        rdy = (force_ready >= 0) ? force_ready[0] : ($urandom_range(0, 3) != 0);
        conv_ready_i = rdy;
        if (cyc == rsp_valid_cyc) begin
            conv_valid_i = 1'b1;
            conv_dout_i  = conv_data(lat_addr);
        end else if (stray_en && cyc > busy_end && $urandom_range(0, 4) == 0) begin
            conv_valid_i = 1'b1;
            conv_dout_i  = $urandom;
        end else begin
            conv_valid_i = 1'b0;
            conv_dout_i  = $urandom;
        end

        if (cyc > busy_end && rdy && rq != '0) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                int k2 = (model_last + i) % N;
                if (w < 0 && pend[k2]) w = k2;
            end
            t.cyc = cyc; t.idx = w; t.we = p_we[w]; t.addr = p_addr[w];
            t.data = p_we[w] ? p_wdata[w] : '0; t.err = 1'b0;
            gnt_exp_q.push_back(t);
            model_last = w;
            pend[w] = 1'b0;
            if (!p_we[w]) begin
                d = (next_delay > 0) ? next_delay : $urandom_range(1, TMO + 1);
                next_delay = 0;
                r.cyc  = cyc + ((d <= TMO) ? d : TMO);
                r.idx  = w; r.we = 1'b0; r.addr = p_addr[w];
                r.data = (d <= TMO) ? conv_data(p_addr[w]) : '0;
                r.err  = (d > TMO);
                rsp_exp_q.push_back(r);
                busy_end      = r.cyc;
                rsp_valid_cyc = (d <= TMO) ? cyc + d : -1;
            end
        end
        #1;
        if (conv_en_o && !conv_we_o) lat_addr = conv_addr_o;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        pend[k] = 1'b1; p_we[k] = we; p_addr[k] = a; p_wdata[k] = wd;
    endtask

    // scoreboard monitor
    txn_t me;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (gnt_o != '0) begin
                if (gnt_exp_q.size() == 0) begin
                    check("gnt_unexpected", 64'(gnt_o), 64'd0);
                end else begin
                    me = gnt_exp_q.pop_front();
                    check("gnt_cycle", 64'(cyc), 64'(me.cyc));
                    check("gnt_vec", 64'(gnt_o), 64'(1) << me.idx);
                    check("gnt_conv_en", 64'(conv_en_o), 64'd1);
                    check("gnt_conv_we", 64'(conv_we_o), 64'(me.we));
                    check("gnt_conv_addr", 64'(conv_addr_o), 64'(me.addr));
                    check("gnt_conv_din", 64'(conv_din_o), 64'(me.data));
                end
            end else begin
                check("nogrant_conv_en", 64'(conv_en_o), 64'd0);
            end
            if (rvalid_o != '0) begin
                if (rsp_exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rvalid_o), 64'd0);
                end else begin
                    me = rsp_exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(me.cyc));
                    check("rsp_vec", 64'(rvalid_o), 64'(1) << me.idx);
                    check("rsp_data", 64'(rdata_o), 64'(me.data));
                    check("rsp_err", 64'(rerr_o), 64'(me.err));
                end
            end
        end
    end

    logic [N-1:0] seq_w [4];
    logic [N-1:0] seq_r [5];

    initial begin
        model_reset();
        for (int k = 0; k < N; k++) begin
            p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0;
        end
        seq_w[0] = 2'b01; seq_w[1] = 2'b10; seq_w[2] = 2'b01; seq_w[3] = 2'b10;
        seq_r[0] = 2'b01; seq_r[1] = 2'b00; seq_r[2] = 2'b10; seq_r[3] = 2'b00; seq_r[4] = 2'b01;
        repeat (2) @(posedge clk_i);
        do_reset();

        // single read from requester 0
        force_ready = 1; next_delay = 1;
        set_req(0, 1'b0, 7'h05, '0);
        drive_cycle();
        check("t1_gnt", 64'(gnt_o), 64'd1);
        check("t1_conv_en", 64'(conv_en_o), 64'd1);
        check("t1_addr", 64'(conv_addr_o), 64'h05);
        drive_cycle();
        check("t1_rvalid", 64'(rvalid_o), 64'd1);
        check("t1_rdata", 64'(rdata_o), 64'hDEADBEEF);
        check("t1_rerr", 64'(rerr_o), 64'd0);

        // both writing, alternating grants
        do_reset();
        force_ready = 1;
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 7'($urandom), $urandom);
            set_req(1, 1'b1, 7'($urandom), $urandom);
            drive_cycle();
            check("wr_seq_gnt", 64'(gnt_o), 64'(seq_w[c]));
            check("wr_seq_we", 64'(conv_we_o), 64'd1);
        end
        for (int k = 0; k < N; k++) pend[k] = 1'b0;

        // both reading
        do_reset();
        force_ready = 1;
        for (int c = 0; c < 5; c++) begin
            if (!pend[0]) set_req(0, 1'b0, 7'($urandom), '0);
            if (!pend[1]) set_req(1, 1'b0, 7'($urandom), '0);
            next_delay = 1;
            drive_cycle();
            check("rd_seq_gnt", 64'(gnt_o), 64'(seq_r[c]));
        end
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        drive_cycle();

        // converter not ready
        do_reset();
        set_req(1, 1'b1, 7'h11, 32'hCAFE0001);
        force_ready = 0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            check("nordy_gnt", 64'(gnt_o), 64'd0);
            check("nordy_en", 64'(conv_en_o), 64'd0);
        end
        force_ready = 1;
        drive_cycle();
        check("rdy_gnt", 64'(gnt_o), 64'b10);

        // read timeout
        do_reset();
        force_ready = 1; next_delay = TMO + 1;
        set_req(0, 1'b0, 7'h22, '0);
        drive_cycle();
        for (int c = 1; c <= TMO; c++) begin
            if (c == TMO) set_req(1, 1'b0, 7'h23, '0);
            drive_cycle();
            check("tmo_rvalid", 64'(rvalid_o), (c == TMO) ? 64'd1 : 64'd0);
        end
        check("tmo_err", 64'(rerr_o), 64'd1);
        check("tmo_data", 64'(rdata_o), 64'd0);
        next_delay = 1;
        drive_cycle();
        check("tmo_next_gnt", 64'(gnt_o), 64'b10);
        drive_cycle();

        // reset during RD_WAIT, then a late conv_valid_i
        do_reset();
        force_ready = 1; next_delay = 1;
        set_req(1, 1'b0, 7'h33, '0);
        drive_cycle();
        @(posedge clk_i); #1;
        rst_i = 1'b1; cyc++;
        rsp_exp_q.delete();
        #1;
        check("midrst_rvalid", 64'(rvalid_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = '0; conv_valid_i = 1'b1; conv_dout_i = 32'hBAD0BAD0; cyc++;
        model_reset();
        #1;
        check("postrst_rvalid", 64'(rvalid_o), 64'd0);
        force_ready = 1;
        set_req(0, 1'b0, 7'h01, '0);
        set_req(1, 1'b0, 7'h02, '0);
        next_delay = 1;
        drive_cycle();
        check("postrst_gnt", 64'(gnt_o), 64'b01);
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        drive_cycle();

        // randomized traffic with stray valids and dropped requests
        do_reset();
        stray_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1)
                    set_req(k, 1'($urandom_range(0, 1)), 7'($urandom), $urandom);
                else if (pend[k] && $urandom_range(0, 19) == 0)
                    pend[k] = 1'b0;
            end
            drive_cycle();
        end
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        stray_en = 1'b0;
        repeat (TMO + 3) drive_cycle();

        check("gnt_queue_empty", 64'(gnt_exp_q.size()), 64'd0);
        check("rsp_queue_empty", 64'(rsp_exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
